// File: rtl/data_mem_ctrl_pkg.sv
// Shared definitions for the data-memory access controller.
//  - funct3 access-size encodings and the controller FSM state type
//  - helpers for access size, alignment, store byte lanes and store data replication
package data_mem_ctrl_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_t;

  // Reserved funct3 codes fall through to a word access.
  function automatic size_t size_of(input logic [2:0] f3);
    size_t sz;
    case (f3)
      F3_B, F3_BU: sz = SZ_BYTE;
      F3_H, F3_HU: sz = SZ_HALF;
      default:     sz = SZ_WORD;
    endcase
    return sz;
  endfunction

  function automatic logic is_aligned(input logic [2:0] f3, input logic [1:0] off);
    logic ok;
    case (size_of(f3))
      SZ_BYTE: ok = 1'b1;
      SZ_HALF: ok = (off[0] == 1'b0);
      default: ok = (off == 2'b00);
    endcase
    return ok;
  endfunction

  function automatic logic [3:0] byte_en(input logic [2:0] f3, input logic [1:0] off);
    logic [3:0] be;
    case (size_of(f3))
      SZ_BYTE: be = 4'b0001 << off;
      SZ_HALF: be = off[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  // Replicate the significant low bytes across every lane so the bus can
  // pick them up under whichever byte enables are active.
  function automatic logic [31:0] lane_wdata(input logic [2:0] f3, input logic [31:0] d);
    logic [31:0] w;
    case (size_of(f3))
      SZ_BYTE: w = {4{d[7:0]}};
      SZ_HALF: w = {2{d[15:0]}};
      default: w = d;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/data_mem_ctrl_load_extend.sv
// Combinational load-data extraction.
//  rdata  : bus read word
//  off    : byte offset of the access within the word
//  funct3 : access size/sign (LB, LH, LW, LBU, LHU; reserved codes act as LW)
//  ext    : selected lane, sign- or zero-extended to 32 bits
module load_extend
  import data_mem_ctrl_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  output logic [31:0] ext
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane selection followed by sign/zero extension.
  always_comb begin
    byte_sel = 8'h00;
    half_sel = 16'h0000;
    ext      = rdata;
    case (off)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      2'd3:    byte_sel = rdata[31:24];
      default: byte_sel = rdata[7:0];
    endcase
    if (off[1]) begin
      half_sel = rdata[31:16];
    end else begin
      half_sel = rdata[15:0];
    end
    case (funct3)
      F3_B:    ext = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   ext = {24'h000000, byte_sel};
      F3_H:    ext = {{16{half_sel[15]}}, half_sel};
      F3_HU:   ext = {16'h0000, half_sel};
      default: ext = rdata;
    endcase
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// Data-memory access controller between the MEM stage and a req/ack word bus.
//  clk, rst               : clock (rising edge), asynchronous active-high reset
//  memRead, memWrite      : load/store request from MEM (both high -> store)
//  funct3, address        : access size/sign and byte address
//  memWriteData           : store data, low bytes significant for SB/SH
//  memReadData            : extended load result, held between loads
//  stall                  : core must hold this cycle
//  misaligned, busError   : single-cycle pulses for alignment reject / timeout abort
//  busReq/busWe/busAddr/busWData/busByteEn : bus request, held stable until busAck
//  busAck, busRData       : bus completion and read word
module data_mem_ctrl
  import data_mem_ctrl_pkg::*;
#(
  parameter int WORD_BITWIDTH  = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     memRead,
  input  logic                     memWrite,
  input  logic [2:0]               funct3,
  input  logic [WORD_BITWIDTH-1:0] address,
  input  logic [WORD_BITWIDTH-1:0] memWriteData,
  output logic [WORD_BITWIDTH-1:0] memReadData,
  output logic                     stall,
  output logic                     misaligned,
  output logic                     busError,
  output logic                     busReq,
  output logic                     busWe,
  output logic [WORD_BITWIDTH-1:0] busAddr,
  output logic [WORD_BITWIDTH-1:0] busWData,
  output logic [3:0]               busByteEn,
  input  logic                     busAck,
  input  logic [WORD_BITWIDTH-1:0] busRData
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state;
  state_t           next_state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       load_off;
  logic [2:0]       load_f3;
  logic [31:0]      load_ext;
  logic             req;
  logic             aligned;
  logic             start;
  logic             timeout;

  assign req     = memRead | memWrite;
  assign aligned = is_aligned(funct3, address[1:0]);
  assign start   = (state == ST_IDLE) && req && aligned;
  // An ack on the final counted cycle still wins over the abort.
  assign timeout = (state == ST_ACCESS) && !busAck && (cnt == CNT_LAST);

  // Offset and size are captured at request time, so extraction does not
  // depend on MEM holding address/funct3 through the stall.
  load_extend u_load_extend (
    .rdata  (busRData),
    .off    (load_off),
    .funct3 (load_f3),
    .ext    (load_ext)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state, stall and alignment-reject decode.
  always_comb begin
    next_state = state;
    stall      = 1'b0;
    misaligned = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req) begin
          if (aligned) begin
            stall      = 1'b1;
            next_state = ST_ACCESS;
          end else begin
            misaligned = 1'b1;
            next_state = ST_IDLE;
          end
        end else begin
          next_state = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        stall = 1'b1;
        if (busAck || timeout) begin
          next_state = ST_DONE;
        end else begin
          next_state = ST_ACCESS;
        end
      end
      ST_DONE: begin
        next_state = ST_IDLE;
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  // Bus request capture, timeout counting and load-result registration.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busReq      <= 1'b0;
      busWe       <= 1'b0;
      busAddr     <= '0;
      busWData    <= '0;
      busByteEn   <= 4'b0000;
      memReadData <= '0;
      busError    <= 1'b0;
      cnt         <= '0;
      load_off    <= 2'b00;
      load_f3     <= 3'b000;
    end else begin
      case (state)
        ST_IDLE: begin
          busError <= 1'b0;
          if (start) begin
            busReq    <= 1'b1;
            busWe     <= memWrite;
            busAddr   <= {address[WORD_BITWIDTH-1:2], 2'b00};
            busWData  <= lane_wdata(funct3, memWriteData);
            busByteEn <= byte_en(funct3, address[1:0]);
            cnt       <= '0;
            load_off  <= address[1:0];
            load_f3   <= funct3;
          end else begin
            busReq <= 1'b0;
          end
        end
        ST_ACCESS: begin
          if (busAck) begin
            busReq <= 1'b0;
            if (!busWe) begin
              memReadData <= load_ext;
            end else begin
              memReadData <= memReadData;
            end
          end else if (timeout) begin
            busReq      <= 1'b0;
            memReadData <= '0;
            busError    <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_DONE: begin
          busReq   <= 1'b0;
          busError <= 1'b0;
          cnt      <= '0;
        end
        default: begin
          busReq   <= 1'b0;
          busError <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Scoreboard bench for data_mem_ctrl (TIMEOUT_CYCLES = 4).
// Stimulus pushes expected bus requests and expected completions into queues;
// a negedge monitor pops and compares when the DUT raises busReq, pulses
// misaligned, or ends a stall run.
module tb_data_mem_ctrl;

  localparam logic [2:0] F_B  = 3'b000;
  localparam logic [2:0] F_H  = 3'b001;
  localparam logic [2:0] F_W  = 3'b010;
  localparam logic [2:0] F_R  = 3'b011;
  localparam logic [2:0] F_BU = 3'b100;
  localparam logic [2:0] F_HU = 3'b101;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        memRead = 1'b0;
  logic        memWrite = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] address = 32'h0;
  logic [31:0] memWriteData = 32'h0;
  logic [31:0] memReadData;
  logic        stall;
  logic        misaligned;
  logic        busError;
  logic        busReq;
  logic        busWe;
  logic [31:0] busAddr;
  logic [31:0] busWData;
  logic [3:0]  busByteEn;
  logic        busAck = 1'b0;
  logic [31:0] busRData = 32'h0;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [3:0]  be;
  } bus_t;

  typedef struct {
    logic        is_mis;
    logic [31:0] rdata;
    logic        berr;
    int          stall_len;
  } done_t;

  bus_t  bus_q[$];
  done_t done_q[$];
  int    checks = 0;
  int    failures = 0;
  logic [31:0] model_rd = 32'h0;

  data_mem_ctrl #(.WORD_BITWIDTH(32), .TIMEOUT_CYCLES(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .memRead      (memRead),
    .memWrite     (memWrite),
    .funct3       (funct3),
    .address      (address),
    .memWriteData (memWriteData),
    .memReadData  (memReadData),
    .stall        (stall),
    .misaligned   (misaligned),
    .busError     (busError),
    .busReq       (busReq),
    .busWe        (busWe),
    .busAddr      (busAddr),
    .busWData     (busWData),
    .busByteEn    (busByteEn),
    .busAck       (busAck),
    .busRData     (busRData)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: compares DUT responses against the scoreboard queues.
  always @(negedge clk) begin : mon
    int   stall_run;
    logic req_prev;
    bus_t b;
    done_t d;
    if (rst) begin
      stall_run = 0;
      req_prev  = 1'b0;
    end else begin
      if (busReq && !req_prev) begin
        if (bus_q.size() == 0) begin
          check("unexpected_busreq", 32'd1, 32'd0);
        end else begin
          b = bus_q.pop_front();
          check("busAddr", busAddr, b.addr);
          check("busWe", {31'd0, busWe}, {31'd0, b.we});
          check("busWData", busWData, b.wdata);
          check("busByteEn", {28'd0, busByteEn}, {28'd0, b.be});
        end
      end
      req_prev = busReq;
      if (misaligned) begin
        if (done_q.size() == 0) begin
          check("unexpected_misaligned", 32'd1, 32'd0);
        end else begin
          d = done_q.pop_front();
          check("misaligned_expected", 32'd1, {31'd0, d.is_mis});
          check("mis_stall", {31'd0, stall}, 32'd0);
          check("mis_memReadData", memReadData, d.rdata);
        end
      end
      if (stall) begin
        stall_run++;
      end else if (stall_run > 0) begin
        if (done_q.size() == 0) begin
          check("unexpected_completion", 32'd1, 32'd0);
        end else begin
          d = done_q.pop_front();
          check("completion_expected", {31'd0, d.is_mis}, 32'd0);
          check("memReadData", memReadData, d.rdata);
          check("busError", {31'd0, busError}, {31'd0, d.berr});
          check("stall_len", stall_run, d.stall_len);
        end
        stall_run = 0;
      end
    end
  end

  // Drives one request (called just after a posedge) and plays the bus slave.
  task automatic run(input logic rd, input logic wr, input logic [2:0] f3,
                     input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [31:0] rdata, input int ack_after);
    int acc;
    bit ended;
    acc = 0;
    ended = 1'b0;
    memRead = rd;
    memWrite = wr;
    funct3 = f3;
    address = addr;
    memWriteData = wdata;
    for (int c = 0; c < 400; c++) begin
      @(posedge clk);
      #1;
      busAck = 1'b0;
      if (busReq) begin
        if (acc == ack_after) begin
          busAck = 1'b1;
          busRData = rdata;
        end
        acc++;
      end
      if (!stall) begin
        ended = 1'b1;
        break;
      end
    end
    if (!ended) check("wait_bound", 32'd0, 32'd1);
    memRead = 1'b0;
    memWrite = 1'b0;
    busAck = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] rdata,
                         input int ack_after, input logic [3:0] be, input logic [31:0] result);
    bus_t b;
    done_t d;
    b = '{addr: {addr[31:2], 2'b00}, we: 1'b0, wdata: 32'h0, be: be};
    d = '{is_mis: 1'b0, rdata: result, berr: 1'b0, stall_len: 2 + ack_after};
    bus_q.push_back(b);
    done_q.push_back(d);
    model_rd = result;
    run(1'b1, 1'b0, f3, addr, 32'h0, rdata, ack_after);
  endtask

  task automatic do_store(input logic rd, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] data, input logic [31:0] exp_wdata, input logic [3:0] be);
    bus_t b;
    done_t d;
    b = '{addr: {addr[31:2], 2'b00}, we: 1'b1, wdata: exp_wdata, be: be};
    d = '{is_mis: 1'b0, rdata: model_rd, berr: 1'b0, stall_len: 2};
    bus_q.push_back(b);
    done_q.push_back(d);
    run(rd, 1'b1, f3, addr, data, 32'h5A5A5A5A, 0);
  endtask

  task automatic do_mis(input logic rd, input logic wr, input logic [2:0] f3, input logic [31:0] addr);
    done_t d;
    d = '{is_mis: 1'b1, rdata: model_rd, berr: 1'b0, stall_len: 0};
    done_q.push_back(d);
    run(rd, wr, f3, addr, 32'hFFFFFFFF, 32'h0, 0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus_t b;
    done_t d;
    #23;
    check("rst_busReq", {31'd0, busReq}, 32'd0);
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_memReadData", memReadData, 32'h0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("init_busAddr", busAddr, 32'h0);
    check("init_busByteEn", {28'd0, busByteEn}, 32'h0);
    check("init_misaligned", {31'd0, misaligned}, 32'd0);
    check("init_busError", {31'd0, busError}, 32'd0);

    // Loads with the ack in the first ACCESS cycle.
    do_load(F_W,  32'h00000100, 32'hDEADBEEF, 0, 4'b1111, 32'hDEADBEEF);
    do_load(F_B,  32'h00000103, 32'h80112233, 0, 4'b1000, 32'hFFFFFF80);
    do_load(F_BU, 32'h00000103, 32'h80112233, 0, 4'b1000, 32'h00000080);
    do_load(F_H,  32'h00000102, 32'h80112233, 0, 4'b1100, 32'hFFFF8011);
    do_load(F_HU, 32'h00000100, 32'h1234F00D, 0, 4'b0011, 32'h0000F00D);
    do_load(F_B,  32'h00000101, 32'h80112233, 0, 4'b0010, 32'h00000022);

    // Stores: read data must hold.
    do_store(1'b0, F_H, 32'h00000202, 32'h0000ABCD, 32'hABCDABCD, 4'b1100);
    do_store(1'b0, F_B, 32'h00000301, 32'h12345678, 32'h78787878, 4'b0010);
    do_store(1'b0, F_W, 32'h00000400, 32'hCAFEF00D, 32'hCAFEF00D, 4'b1111);
    do_store(1'b1, F_W, 32'h00000404, 32'h01020304, 32'h01020304, 4'b1111);

    // Alignment rejects, including a reserved funct3 acting as word.
    do_mis(1'b1, 1'b0, F_W, 32'h00000101);
    do_mis(1'b1, 1'b0, F_H, 32'h00000103);
    do_mis(1'b0, 1'b1, F_H, 32'h00000201);
    do_mis(1'b1, 1'b0, F_R, 32'h00000002);
    do_load(F_R, 32'h00000500, 32'h87654321, 0, 4'b1111, 32'h87654321);

    // Late acks, including on the last cycle before the abort.
    do_load(F_W, 32'h00000600, 32'h0BADC0DE, 2, 4'b1111, 32'h0BADC0DE);
    do_load(F_W, 32'h00000604, 32'h11111111, 3, 4'b1111, 32'h11111111);

    // Ack withheld: four ACCESS cycles then an aborted DONE.
    b = '{addr: 32'h00000700, we: 1'b0, wdata: 32'h0, be: 4'b1111};
    d = '{is_mis: 1'b0, rdata: 32'h0, berr: 1'b1, stall_len: 5};
    bus_q.push_back(b);
    done_q.push_back(d);
    model_rd = 32'h0;
    run(1'b1, 1'b0, F_W, 32'h00000700, 32'h0, 32'hFFFFFFFF, -1);

    do_load(F_W, 32'h00000704, 32'h24682468, 0, 4'b1111, 32'h24682468);

    // Reset in the middle of ACCESS.
    b = '{addr: 32'h00000100, we: 1'b0, wdata: 32'h0, be: 4'b1111};
    bus_q.push_back(b);
    memRead = 1'b1;
    funct3 = F_W;
    address = 32'h00000100;
    memWriteData = 32'h0;
    @(posedge clk);
    #1;
    check("pre_rst_busReq", {31'd0, busReq}, 32'd1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    memRead = 1'b0;
    #1;
    check("midrst_busReq", {31'd0, busReq}, 32'd0);
    check("midrst_stall", {31'd0, stall}, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check("postrst_busAddr", busAddr, 32'h0);
    check("postrst_busWe", {31'd0, busWe}, 32'd0);
    check("postrst_busWData", busWData, 32'h0);
    check("postrst_busByteEn", {28'd0, busByteEn}, 32'h0);
    check("postrst_memReadData", memReadData, 32'h0);
    check("postrst_busError", {31'd0, busError}, 32'd0);
    model_rd = 32'h0;
    @(posedge clk);
    #1;
    do_load(F_W, 32'h00000100, 32'h13579BDF, 0, 4'b1111, 32'h13579BDF);

    repeat (3) @(posedge clk);
    #1;
    check("bus_q_drained", bus_q.size(), 32'd0);
    check("done_q_drained", done_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
